// File: rtl/treasure_pkg.sv
// Shared types for the treasure result scheduler: FSM states, result width,
// classifier result codes and a small saturating-count helper.
package treasure_pkg;

  localparam int RESULT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_SETTLE,
    ST_COMPARE,
    ST_PRESENT,
    ST_WAIT_ACK_LO
  } sched_state_e;

  typedef enum logic [RESULT_W-1:0] {
    RES_NONE            = 9'd0,
    RES_BLUE_SQUARE     = 9'd1,
    RES_BLUE_TRIANGLE   = 9'd2,
    RES_BLUE_DIAMOND    = 9'd3,
    RES_RED_SQUARE      = 9'd4,
    RES_RED_TRIANGLE    = 9'd5,
    RES_RED_DIAMOND     = 9'd6
  } result_code_e;

  // Increment that sticks at the limit instead of wrapping.
  function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous level, with registered
// single-cycle rise and fall pulses derived from the synchronised level.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta   <= async_in;
      sync_q <= meta;
      sync_d <= sync_q;
      rise   <= sync_q & ~sync_d;
      fall   <= ~sync_q & sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/treasure_result_scheduler.sv
// Frame-level scheduler: samples the classifier result once per frame, debounces
// it over several frames and hands each new stable value to the Arduino via REQ/ACK.
module treasure_result_scheduler #(
  parameter int RESULT_W      = treasure_pkg::RESULT_W,
  parameter int STABLE_FRAMES = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int ACK_TIMEOUT   = 1000000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                VSYNC,
  input  logic                ENABLE,
  input  logic [RESULT_W-1:0] RESULT_IN,
  input  logic                ACK_IN,
  output logic [RESULT_W-1:0] RESULT_OUT,
  output logic                REQ_OUT,
  output logic                FRAME_START,
  output logic [15:0]         FRAME_CNT,
  output logic                TIMEOUT_ERR,
  output logic                BUSY
);

  import treasure_pkg::*;

  localparam int SETTLE_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int TIMEOUT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [SETTLE_W-1:0]  SETTLE_LOAD  = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(ACK_TIMEOUT - 1);
  localparam logic [3:0]           STABLE_N     = 4'(STABLE_FRAMES);

  sched_state_e          state;
  sched_state_e          next_state;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [TIMEOUT_W-1:0]  timeout_cnt;
  logic [3:0]            match_cnt;
  logic [3:0]            match_upd;
  logic [RESULT_W-1:0]   cand;
  logic [RESULT_W-1:0]   last_sample;
  logic [RESULT_W-1:0]   reported;
  logic                  present_go;
  logic                  settle_done;
  logic                  timeout_hit;

  logic vs_s, vs_rise, vs_fall;
  logic ack_s, ack_rise, ack_fall;
  logic sync_unused;

  sync_edge_det u_vsync_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .async_in (VSYNC),
    .sync_out (vs_s),
    .rise     (vs_rise),
    .fall     (vs_fall)
  );

  sync_edge_det u_ack_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .async_in (ACK_IN),
    .sync_out (ack_s),
    .rise     (ack_rise),
    .fall     (ack_fall)
  );

  assign sync_unused = vs_s | ack_rise | ack_fall;
  assign FRAME_START = vs_fall;

  assign settle_done = (settle_cnt == '0);
  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

  // The decision to present uses the match count as it will be after this compare.
  always_comb begin
    match_upd  = (cand == last_sample) ? sat_inc4(match_cnt, STABLE_N) : 4'd1;
    present_go = (match_upd == STABLE_N) && (cand != reported);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (state != ST_IDLE && !ENABLE) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:        if (ENABLE) next_state = ST_WAIT_VS;
        ST_WAIT_VS:     if (vs_rise) next_state = ST_SETTLE;
        ST_SETTLE:      if (!vs_rise && settle_done) next_state = ST_COMPARE;
        ST_COMPARE:     next_state = present_go ? ST_PRESENT : ST_WAIT_VS;
        ST_PRESENT: begin
          if (ack_s)            next_state = ST_WAIT_ACK_LO;
          else if (timeout_hit) next_state = ST_WAIT_VS;
        end
        ST_WAIT_ACK_LO: if (!ack_s) next_state = ST_WAIT_VS;
        default:        next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    BUSY = !(state inside {ST_IDLE, ST_WAIT_VS});
  end

  // Frames are counted regardless of state or enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      FRAME_CNT <= '0;
    end else if (vs_rise) begin
      FRAME_CNT <= FRAME_CNT + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      settle_cnt  <= '0;
      timeout_cnt <= '0;
      match_cnt   <= '0;
      cand        <= '0;
      last_sample <= '0;
      reported    <= '0;
      RESULT_OUT  <= '0;
      REQ_OUT     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      REQ_OUT <= (next_state == ST_PRESENT);
      if (!ENABLE) begin
        match_cnt <= '0;
      end else begin
        case (state)
          ST_WAIT_VS: begin
            if (vs_rise) settle_cnt <= SETTLE_LOAD;
          end
          ST_SETTLE: begin
            if (vs_rise)          settle_cnt <= SETTLE_LOAD;
            else if (settle_done) cand <= RESULT_IN;
            else                  settle_cnt <= settle_cnt - 1'b1;
          end
          ST_COMPARE: begin
            match_cnt <= match_upd;
            if (cand != last_sample) last_sample <= cand;
            if (present_go) begin
              RESULT_OUT  <= cand;
              timeout_cnt <= '0;
            end
          end
          // A timed-out value leaves reported untouched so it is offered again.
          ST_PRESENT: begin
            if (ack_s)            reported <= RESULT_OUT;
            else if (timeout_hit) TIMEOUT_ERR <= 1'b1;
            else                  timeout_cnt <= timeout_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
